// File: rtl/fixed2float_arbiter_pkg.sv
// f2f_arb_pkg: shared constants, tag type and helpers for the fixed2float arbiter
package f2f_arb_pkg;
    localparam int DATA_W  = 32;
    localparam int MAX_REQ = 8;

    typedef struct packed {
        logic       vld;
        logic [2:0] idx;
    } tag_t;

    function automatic logic [3:0] popcount(input logic [MAX_REQ-1:0] v);
        popcount = '0;
        for (int i = 0; i < MAX_REQ; i++) popcount += 4'(v[i]);
    endfunction
endpackage

// File: rtl/fixed2float_arbiter_if.sv
// fixed2float_arbiter_if: requester, response and converter signals of the arbiter
interface fixed2float_arbiter_if
    import f2f_arb_pkg::*;
#(
    parameter int N_REQ = 4
);
    localparam int IW = $clog2(N_REQ + 1);

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_value;
    logic [N_REQ-1:0]        req_ready;
    logic [DATA_W-1:0]       conv_value;
    logic [DATA_W-1:0]       conv_result;
    logic [N_REQ-1:0]        rsp_valid;
    logic [N_REQ*DATA_W-1:0] rsp_result;
    logic [N_REQ-1:0]        rsp_ready;
    logic [IW-1:0]           inflight;

    modport slave (
        input  req_valid, req_value, conv_result, rsp_ready,
        output req_ready, conv_value, rsp_valid, rsp_result, inflight
    );

    modport master (
        output req_valid, req_value, conv_result, rsp_ready,
        input  req_ready, conv_value, rsp_valid, rsp_result, inflight
    );
endinterface

// File: rtl/fixed2float_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting just after the last grant
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] elig,
    input  logic [2:0]       rr_ptr,
    output logic [N_REQ-1:0] grant,
    output logic [2:0]       grant_idx,
    output logic             any_grant
);
    // walk rr_ptr+1, rr_ptr+2, ... with wrap and take the first eligible index
    always_comb begin
        int j;
        j         = 0;
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            j = (int'(rr_ptr) + k) % N_REQ;
            if (!any_grant && elig[j]) begin
                grant[j]  = 1'b1;
                grant_idx = 3'(j);
                any_grant = 1'b1;
            end
        end
    end
endmodule

// File: rtl/fixed2float_arbiter.sv
// fixed2float_arbiter: round-robin sharing of one pipelined fixed2float converter
module fixed2float_arbiter
    import f2f_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int LATENCY = 6
) (
    input  logic                  aclk,
    input  logic                  areset,
    fixed2float_arbiter_if.slave  bus
);
    localparam int IW = $clog2(N_REQ + 1);

    logic [N_REQ-1:0]  pending, pending_nxt, elig, grant, rsp_done;
    logic [2:0]        rr_ptr, grant_idx;
    logic              any_grant;
    logic [DATA_W-1:0] sel_value;
    tag_t              pipe [LATENCY+1];

    assign elig        = bus.req_valid & ~pending;
    assign rsp_done    = bus.rsp_valid & bus.rsp_ready;
    assign pending_nxt = (pending | grant) & ~rsp_done;
    assign bus.req_ready = areset ? '0 : grant;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .elig      (elig),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    // operand of the granted requester (one-hot select)
    always_comb begin
        sel_value = '0;
        for (int i = 0; i < N_REQ; i++)
            if (grant[i]) sel_value = bus.req_value[DATA_W*i +: DATA_W];
    end

    // issue, tag tracking, result capture and pending bookkeeping
    always_ff @(posedge aclk) begin
        if (areset) begin
            pending        <= '0;
            rr_ptr         <= 3'(N_REQ - 1);
            bus.conv_value <= '0;
            bus.rsp_valid  <= '0;
            bus.rsp_result <= '0;
            bus.inflight   <= '0;
            for (int s = 0; s <= LATENCY; s++) pipe[s] <= '0;
        end else begin
            pipe[0] <= '{vld: any_grant, idx: grant_idx};
            for (int s = 1; s <= LATENCY; s++) pipe[s] <= pipe[s-1];
            if (any_grant) begin
                bus.conv_value <= sel_value;
                rr_ptr         <= grant_idx;
            end
            pending      <= pending_nxt;
            bus.inflight <= IW'(popcount(MAX_REQ'(pending_nxt)));
            for (int i = 0; i < N_REQ; i++) begin
                if (rsp_done[i]) bus.rsp_valid[i] <= 1'b0;
                if (pipe[LATENCY].vld && pipe[LATENCY].idx == 3'(i)) begin
                    bus.rsp_valid[i]                    <= 1'b1;
                    bus.rsp_result[DATA_W*i +: DATA_W]  <= bus.conv_result;
                end
            end
        end
    end
endmodule

// File: doc/fixed2float_arbiter.md
Name: fixed2float_arbiter

Overview:
- Shares one fixed-latency, non-handshaked fixed2float converter (32-bit value in, 32-bit result out, pipelined) between N requesters.
- Each requester has a valid/ready request channel and a valid/ready response channel.
- Requests are granted round-robin, one per cycle. A tag pipeline tracks which requester owns each in-flight conversion, and each result is routed back to its owner's response register.
- The block sits between the compute lanes and the converter inside the all-in-one float wrapper.

Parameters:
- N_REQ, 4, number of requesters; legal range 2..8.
- LATENCY, 6, converter cycles from a conv_value change to the matching conv_result; must be >= 1.
- DATA_W, 32, operand/result width; fixed at 32.

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- areset  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_value  in  N_REQ*32  per-requester fixed-point operand; slice i = [32*i+31:32*i].
- req_ready  out  N_REQ  one-hot grant; the handshake completes on an edge where valid & ready.
- conv_value  out  32  registered operand driven to the converter.
- conv_result  in  32  converter output.
- rsp_valid  out  N_REQ  per-requester result valid.
- rsp_result  out  N_REQ*32  per-requester float result.
- rsp_ready  in  N_REQ  per-requester result accept.
- inflight  out  $clog2(N_REQ+1)  number of requesters with pending=1.

Behaviour:
- State:
  - pending[N_REQ]: owner has an issued request whose response is not yet consumed.
  - rr_ptr: index of the last grant.
  - tag pipe: LATENCY+1 stages of {vld, idx}.
  - response registers.
- Reset (areset=1 at an edge):
  - pending=0, rr_ptr=N_REQ-1 (so requester 0 has first priority), all tag vld=0.
  - rsp_valid=0, rsp_result=0, conv_value=0, inflight=0.
  - req_ready is 0 during reset.
- Reset mid-operation drops in-flight tags. Converter outputs arriving after reset are ignored.
- Eligibility: elig[i] = req_valid[i] & ~pending[i], using registered pending only.
- Grant is combinational: the first eligible index searching rr_ptr+1, rr_ptr+2, ... with wrap. At most one req_ready bit is high; all are 0 if nothing is eligible.
- On a grant edge (index g):
  - conv_value <= req_value[g]
  - tag stage0 <= {1, g}
  - pending[g] <= 1
  - rr_ptr <= g
- With no grant: conv_value holds its value and stage0.vld <= 0.
- The tag pipe shifts every cycle. Stage LATENCY is aligned with the conv_result for that operand.
- When stage LATENCY has vld=1, the next edge captures rsp_result[idx] <= conv_result and rsp_valid[idx] <= 1.
- Latency: rsp_valid rises LATENCY+1 cycles after the request handshake edge. Throughput is 1 conversion/cycle across requesters and 1 outstanding per requester.
- Response handshake: on rsp_valid[i] & rsp_ready[i], rsp_valid[i] <= 0 and pending[i] <= 0.
  - rsp_result[i] holds its value until overwritten by the next capture.
  - rsp_valid and rsp_result stay stable while rsp_ready is low; there is no timeout.
- A response consumed and a new request valid for the same i in the same cycle: the new grant occurs no earlier than the next cycle, because pending is registered.
- Capture for i and a response handshake for i in the same cycle cannot happen: pending blocks reissue, so a slot is never overwritten.
- Capture for i and a grant for j≠i in the same cycle are independent.
- inflight = popcount(pending), registered, consistent with pending after each edge.
- Requesters must hold req_valid/req_value stable until granted. The arbiter does not check this.

Decomposition:
- Package f2f_arb_pkg holds:
  - DATA_W constant
  - MAX_REQ=8
  - typedef tag_t {logic vld; logic [2:0] idx;}
  - function popcount
- Sub-module rr_arbiter (N_REQ parameter; inputs elig and rr_ptr; outputs one-hot grant, grant_idx, any_grant). It is purely combinational; the pointer register lives in the top module.

Test Plan:
- Bench converter stub: a LATENCY=6 delay line returning value XOR 32'hFFFFFFFF.
- Single request: req0 value 32'h40f8a3d7 → req_ready[0] is high the same cycle; conv_value=32'h40f8a3d7 next cycle; rsp_valid[0] rises 7 cycles after the handshake with rsp_result=32'hBF075C28; inflight 1 then 0 after rsp_ready.
- All four requesters valid from reset with values 1,2,3,4 → grants in order 0,1,2,3 on consecutive cycles; each rsp_valid[i] rises 7 cycles after its grant with ~value; inflight peaks at 4.
- Round-robin fairness: after grant to 2, req1 and req3 both valid → 3 is granted first, then 1.
- Backpressure: rsp_ready[0]=0 for 20 cycles with req0 re-asserted → req_ready[0] stays 0 and rsp_result[0] stays stable. With rsp_ready=1, the new grant comes on the cycle after the response handshake.
- Reset mid-flight: areset pulsed 3 cycles after 2 grants → all rsp_valid stay 0 afterwards, including when the stub emits the stale results; inflight=0; the next request gets a correct response.
- Back-to-back unique values on req3 (32'hc0f8a3d7, then 32'h00000000) with rsp_ready tied high → each response matches its own operand, and the second grant occurs exactly 1 cycle after the first response is consumed.
